// File: rtl/llc_input_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : llc_input_arbiter_pkg                                  |
// | Brief   : Shared LLC front-end types and line-address helpers    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package llc_input_arbiter_pkg;

  // Widest line address the slice helpers accept
  localparam int LLC_ADDR_MAX_W = 64;

  // Default line breakdown: 18-bit tag over an 8-bit set index
  typedef struct packed {
    logic [17:0] tag;
    logic [7:0]  set;
  } llc_line_t;

  // Channel index width; a single channel still needs one bit
  function automatic int llc_ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Tag field: everything above the set index
  function automatic logic [LLC_ADDR_MAX_W-1:0] llc_addr_tag(
    input logic [LLC_ADDR_MAX_W-1:0] addr,
    input int                        set_w
  );
    return addr >> set_w;
  endfunction

  // Set field: the low set_w bits
  function automatic logic [LLC_ADDR_MAX_W-1:0] llc_addr_set(
    input logic [LLC_ADDR_MAX_W-1:0] addr,
    input int                        set_w
  );
    return addr & ((64'd1 << set_w) - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/llc_input_arbiter_rr_picker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : llc_rr_picker                                          |
// | Brief   : Rotate-by-pointer priority encoder (one-hot + index)   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module llc_rr_picker #(
  parameter int NCH  = 4,
  parameter int CH_W = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [CH_W-1:0] idx,
  output logic            any
);

  logic [CH_W-1:0] w_cand;

  // Scan from ptr upward, wrapping modulo NCH; first requester wins
  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    w_cand = '0;
    for (int k = 0; k < NCH; k++) begin
      w_cand = CH_W'((int'(ptr) + k) % NCH);
      if (!any && req[w_cand]) begin
        any         = 1'b1;
        gnt[w_cand] = 1'b1;
        idx         = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/llc_input_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : llc_input_arbiter                                      |
// | Brief   : N-channel LLC input arbiter, tag/set decode, one-entry |
// |           registered output stage and stall-release detection   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module llc_input_arbiter
  import llc_input_arbiter_pkg::*;
#(
  parameter  int NCH         = 4,
  parameter  int LINE_ADDR_W = 26,
  parameter  int SET_W       = 8,
  parameter  int RR          = 0,
  localparam int TAG_W       = LINE_ADDR_W - SET_W,
  localparam int CH_W        = llc_ch_w(NCH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             in_valid,
  input  logic [NCH*LINE_ADDR_W-1:0] in_addr,
  input  logic [NCH-1:0]             in_block,
  output logic [NCH-1:0]             in_ready,
  input  logic                       resume_valid,
  input  logic [LINE_ADDR_W-1:0]     resume_addr,
  output logic                       resume_ready,
  input  logic                       stall_valid,
  input  logic [TAG_W-1:0]           stall_tag,
  input  logic [SET_W-1:0]           stall_set,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_resume,
  output logic [CH_W-1:0]            out_ch,
  output logic [TAG_W-1:0]           out_tag,
  output logic [SET_W-1:0]           out_set,
  output logic                       stall_clr,
  output logic                       idle
);

  logic                   w_load;
  logic                   w_grant_res;
  logic                   w_grant_ch;
  logic                   w_any;
  logic [NCH-1:0]         w_elig;
  logic [NCH-1:0]         w_gnt;
  logic [CH_W-1:0]        w_idx;
  logic [CH_W-1:0]        r_rr_ptr;
  logic [LINE_ADDR_W-1:0] w_addr_arr [NCH];
  logic [LINE_ADDR_W-1:0] w_win_addr;
  logic [TAG_W-1:0]       w_tag;
  logic [SET_W-1:0]       w_set;
  logic                   w_stall_hit;

  // Unpack the flat address bus into one entry per channel
  for (genvar gi = 0; gi < NCH; gi++) begin : g_addr
    assign w_addr_arr[gi] = in_addr[gi*LINE_ADDR_W +: LINE_ADDR_W];
  end

  // Output stage can take a new decision when empty or being drained;
  // gating with rst keeps the pop strobes low during reset
  assign w_load      = rst && (!out_valid || out_ready);
  assign w_elig      = in_valid & ~in_block;
  assign w_grant_res = w_load && resume_valid;
  assign w_grant_ch  = w_load && !resume_valid && w_any;

  assign in_ready     = w_grant_ch ? w_gnt : '0;
  assign resume_ready = w_grant_res;

  llc_rr_picker #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_picker (
    .req (w_elig),
    .ptr (r_rr_ptr),
    .gnt (w_gnt),
    .idx (w_idx),
    .any (w_any)
  );

  // Winning address and its tag/set split
  assign w_win_addr  = resume_valid ? resume_addr : w_addr_arr[w_idx];
  assign w_tag       = TAG_W'(llc_addr_tag(LLC_ADDR_MAX_W'(w_win_addr), SET_W));
  assign w_set       = SET_W'(llc_addr_set(LLC_ADDR_MAX_W'(w_win_addr), SET_W));
  assign w_stall_hit = stall_valid && (w_idx == '0) &&
                       (w_tag == stall_tag) && (w_set == stall_set);

  // Round-robin pointer: advances past the granted channel only
  if (RR != 0 && NCH > 1) begin : g_rr
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_rr_ptr <= '0;
      end else if (w_grant_ch) begin
        r_rr_ptr <= (w_idx == CH_W'(NCH - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end else begin : g_fixed
    assign r_rr_ptr = '0;
  end

  // Registered decision stage; stall_clr is a single-cycle pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_resume <= 1'b0;
      out_ch     <= '0;
      out_tag    <= '0;
      out_set    <= '0;
      stall_clr  <= 1'b0;
      idle       <= 1'b0;
    end else begin
      stall_clr <= 1'b0;
      if (w_load) begin
        if (w_grant_res) begin
          out_valid  <= 1'b1;
          out_resume <= 1'b1;
          out_ch     <= '0;
          out_tag    <= w_tag;
          out_set    <= w_set;
          idle       <= 1'b0;
        end else if (w_grant_ch) begin
          out_valid  <= 1'b1;
          out_resume <= 1'b0;
          out_ch     <= w_idx;
          out_tag    <= w_tag;
          out_set    <= w_set;
          stall_clr  <= w_stall_hit;
          idle       <= 1'b0;
        end else begin
          out_valid  <= 1'b0;
          out_resume <= 1'b0;
          idle       <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_llc_input_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_llc_input_arbiter                                   |
// | Brief   : Directed bench: fixed-priority and round-robin copies  |
// |           of llc_input_arbiter driven from shared stimulus      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_llc_input_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 26;
  localparam int SW  = 8;
  localparam int TW  = AW - SW;
  localparam int CW  = 2;

  logic            clk;
  logic            rst;
  logic [NCH-1:0]  in_valid;
  logic [NCH*AW-1:0] in_addr;
  logic [NCH-1:0]  in_block;
  logic            resume_valid;
  logic [AW-1:0]   resume_addr;
  logic            stall_valid;
  logic [TW-1:0]   stall_tag;
  logic [SW-1:0]   stall_set;
  logic            out_ready;

  logic [NCH-1:0]  in_ready0, in_ready1;
  logic            resume_ready0, resume_ready1;
  logic            out_valid0, out_valid1;
  logic            out_resume0, out_resume1;
  logic [CW-1:0]   out_ch0, out_ch1;
  logic [TW-1:0]   out_tag0, out_tag1;
  logic [SW-1:0]   out_set0, out_set1;
  logic            stall_clr0, stall_clr1;
  logic            idle0, idle1;

  int errors = 0;
  int checks = 0;

  llc_input_arbiter #(.NCH(NCH), .LINE_ADDR_W(AW), .SET_W(SW), .RR(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr),
    .in_block(in_block), .in_ready(in_ready0), .resume_valid(resume_valid),
    .resume_addr(resume_addr), .resume_ready(resume_ready0),
    .stall_valid(stall_valid), .stall_tag(stall_tag), .stall_set(stall_set),
    .out_valid(out_valid0), .out_ready(out_ready), .out_resume(out_resume0),
    .out_ch(out_ch0), .out_tag(out_tag0), .out_set(out_set0),
    .stall_clr(stall_clr0), .idle(idle0)
  );

  llc_input_arbiter #(.NCH(NCH), .LINE_ADDR_W(AW), .SET_W(SW), .RR(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr),
    .in_block(in_block), .in_ready(in_ready1), .resume_valid(resume_valid),
    .resume_addr(resume_addr), .resume_ready(resume_ready1),
    .stall_valid(stall_valid), .stall_tag(stall_tag), .stall_set(stall_set),
    .out_valid(out_valid1), .out_ready(out_ready), .out_resume(out_resume1),
    .out_ch(out_ch1), .out_tag(out_tag1), .out_set(out_set1),
    .stall_clr(stall_clr1), .idle(idle1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int ch, input logic [TW-1:0] t, input logic [SW-1:0] s);
    in_addr[ch*AW +: AW] = {t, s};
  endtask

  initial begin
    rst          = 1'b0;
    in_valid     = 4'b1111;
    in_addr      = '0;
    in_block     = '0;
    resume_valid = 1'b0;
    resume_addr  = '0;
    stall_valid  = 1'b0;
    stall_tag    = '0;
    stall_set    = '0;
    out_ready    = 1'b1;
    for (int i = 0; i < NCH; i++) set_addr(i, TW'(32'h100 + i), SW'(32'h10 + i));

    // Reset state, with requests present
    #1;
    chk("rst_in_ready0", 32'(in_ready0), 32'h0);
    chk("rst_in_ready1", 32'(in_ready1), 32'h0);
    chk("rst_out_valid", 32'(out_valid0), 32'h0);
    chk("rst_idle", 32'(idle0), 32'h0);
    chk("rst_out_tag", 32'(out_tag0), 32'h0);
    tick();
    tick();
    rst      = 1'b1;
    in_valid = 4'b1110;

    // Fixed priority: lowest eligible index
    #1;
    chk("fp_in_ready", 32'(in_ready0), 32'h2);
    chk("rr_first_in_ready", 32'(in_ready1), 32'h2);
    tick();
    chk("fp_out_valid", 32'(out_valid0), 32'h1);
    chk("fp_out_ch", 32'(out_ch0), 32'h1);
    chk("fp_out_tag", 32'(out_tag0), 32'h101);
    chk("fp_out_set", 32'(out_set0), 32'h11);
    chk("fp_in_ready_again", 32'(in_ready0), 32'h2);
    chk("rr_moves_on", 32'(in_ready1), 32'h4);
    tick();
    in_valid = 4'b0000;
    tick();
    chk("nothing_out_valid", 32'(out_valid0), 32'h0);
    chk("nothing_idle", 32'(idle0), 32'h1);
    chk("nothing_hold_ch", 32'(out_ch0), 32'h1);
    chk("nothing_hold_tag", 32'(out_tag0), 32'h101);

    // Mid-operation reset drops the held decision
    in_valid = 4'b1111;
    tick();
    chk("pre_rst_out_valid", 32'(out_valid1), 32'h1);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid0", 32'(out_valid0), 32'h0);
    chk("midrst_out_valid1", 32'(out_valid1), 32'h0);
    chk("midrst_out_tag", 32'(out_tag0), 32'h0);
    chk("midrst_out_set", 32'(out_set1), 32'h0);
    in_valid = 4'b0000;
    rst      = 1'b1;
    tick();
    chk("post_rst_idle", 32'(idle0), 32'h1);

    // Round robin: all channels held for five grants
    in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_in_ready", 32'(in_ready1), 32'h1 << (k % 4));
      chk("fp_hog_in_ready", 32'(in_ready0), 32'h1);
      tick();
      chk("rr_out_ch", 32'(out_ch1), 32'(k % 4));
    end
    chk("rr_ptr_wrapped", 32'(in_ready1), 32'h2);
    in_valid = 4'b0000;
    tick();

    // Resume beats channel 0, channel retries next cycle
    in_valid     = 4'b0001;
    resume_valid = 1'b1;
    resume_addr  = {18'h3AB, 8'h5C};
    #1;
    chk("res_resume_ready", 32'(resume_ready0), 32'h1);
    chk("res_in_ready", 32'(in_ready0), 32'h0);
    tick();
    resume_valid = 1'b0;
    #1;
    chk("res_out_resume", 32'(out_resume0), 32'h1);
    chk("res_out_ch", 32'(out_ch0), 32'h0);
    chk("res_out_tag", 32'(out_tag0), 32'h3AB);
    chk("res_out_set", 32'(out_set0), 32'h5C);
    chk("res_retry_in_ready", 32'(in_ready0), 32'h1);
    tick();
    chk("res_after_resume", 32'(out_resume0), 32'h0);
    chk("res_after_tag", 32'(out_tag0), 32'h100);

    // Backpressure: outputs frozen, no pops, then immediate reload
    in_valid = 4'b0110;
    tick();
    chk("bp_first_ch", 32'(out_ch0), 32'h1);
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready0), 32'h0);
      tick();
      chk("bp_out_valid", 32'(out_valid0), 32'h1);
      chk("bp_out_ch", 32'(out_ch0), 32'h1);
      chk("bp_out_tag", 32'(out_tag0), 32'h101);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready0), 32'h4);
    tick();
    chk("bp_release_ch", 32'(out_ch0), 32'h2);
    chk("bp_release_tag", 32'(out_tag0), 32'h102);

    // Stall release only from channel 0 with matching tag/set
    stall_valid = 1'b1;
    stall_tag   = 18'h123;
    stall_set   = 8'h45;
    set_addr(0, 18'h123, 8'h45);
    in_valid = 4'b0001;
    tick();
    chk("stall_clr_hit", 32'(stall_clr0), 32'h1);
    chk("stall_hit_ch", 32'(out_ch0), 32'h0);
    in_valid = 4'b0000;
    tick();
    chk("stall_clr_pulse", 32'(stall_clr0), 32'h0);
    set_addr(2, 18'h123, 8'h45);
    in_valid = 4'b0100;
    tick();
    chk("stall_ch2_ch", 32'(out_ch0), 32'h2);
    chk("stall_ch2_no_clr", 32'(stall_clr0), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
